// File: rtl/noc_pkg.sv
// Shared ring-NoC definitions: packet field layout, node/timestamp types,
// and the ejection FSM state encoding used by the local packet sink.
package noc_pkg;

  localparam int VALID_BIT = 48;
  localparam int TS_MSB    = 47;
  localparam int TS_LSB    = 32;
  localparam int SRC_MSB   = 31;
  localparam int SRC_LSB   = 16;
  localparam int DST_MSB   = 15;
  localparam int DST_LSB   = 0;

  localparam int NODE_ID_W = 16;
  localparam int TS_W      = 16;

  typedef logic [NODE_ID_W-1:0] node_id_t;
  typedef logic [TS_W-1:0]      timestamp_t;

  typedef enum logic {
    EJ_READY = 1'b0,
    EJ_STALL = 1'b1
  } ej_state_t;

  // Modulo-2^16 age of a packet; unsigned wrap handles timestamp rollover.
  function automatic timestamp_t packet_age(input timestamp_t now, input timestamp_t ts);
    return timestamp_t'(now - ts);
  endfunction

endpackage

// File: rtl/packet_sink_stats.sv
// Statistics stage of the local sink: turns one captured packet per cycle
// into latency, count, misroute and completion statistics.
module packet_sink_stats
  import noc_pkg::*;
#(
  parameter int ROUTER_ID            = 0,
  parameter int NUM_PACKETS_EXPECTED = 20
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             s1_valid,
  input  timestamp_t       s1_ts,
  input  timestamp_t       s1_now,
  input  node_id_t         s1_src,
  input  node_id_t         s1_dst,
  output logic [63:0]      total_packet_received,
  output logic [63:0]      total_latency,
  output logic [15:0]      max_latency,
  output logic [15:0]      misrouted_cnt,
  output logic [15:0]      last_src,
  output logic             all_received
);

  timestamp_t  latency;
  logic [63:0] next_count;
  logic        misrouted;

  always_comb begin
    latency    = packet_age(s1_now, s1_ts);
    next_count = total_packet_received + 64'd1;
    misrouted  = (s1_dst != node_id_t'(ROUTER_ID));
  end

  // Misrouted packets still count toward the totals; only the misroute
  // counter saturates, the 64-bit accumulators are allowed to wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      total_packet_received <= '0;
      total_latency         <= '0;
      max_latency           <= '0;
      misrouted_cnt         <= '0;
      last_src              <= '0;
      all_received          <= 1'b0;
    end else if (s1_valid) begin
      total_packet_received <= next_count;
      total_latency         <= total_latency + {48'd0, latency};
      if (latency > max_latency) begin
        max_latency <= latency;
      end
      last_src <= s1_src;
      if (misrouted && (misrouted_cnt != 16'hFFFF)) begin
        misrouted_cnt <= misrouted_cnt + 16'd1;
      end
      if (next_count >= 64'(NUM_PACKETS_EXPECTED)) begin
        all_received <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/packet_sink_local.sv
// Local ejection endpoint of a ring-NoC router: valid/ready intake throttled
// by a stall FSM, a one-entry capture stage, and the statistics sub-block.
module packet_sink_local
  import noc_pkg::*;
#(
  parameter int NUM_NODES            = 8,
  parameter int ROUTER_ID            = 0,
  parameter int PACKET_SIZE          = 49,
  parameter int EJECT_CYCLE          = 1,
  parameter int NUM_PACKETS_EXPECTED = 20
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [15:0]            clk_counter,
  input  logic                   packet_valid,
  input  logic [PACKET_SIZE-1:0] packet,
  output logic                   packet_ready,
  output logic [63:0]            total_packet_received,
  output logic [63:0]            total_latency,
  output logic [15:0]            max_latency,
  output logic [15:0]            misrouted_cnt,
  output logic [15:0]            last_src,
  output logic                   all_received
);

  localparam int CNT_W = (EJECT_CYCLE > 1) ? $clog2(EJECT_CYCLE) : 1;

  ej_state_t        state, next_state;
  logic [CNT_W-1:0] stall_cnt, next_stall_cnt;
  logic             transfer;

  logic       s1_valid;
  timestamp_t s1_ts;
  timestamp_t s1_now;
  node_id_t   s1_src;
  node_id_t   s1_dst;

  // State register for the ejection throttle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= EJ_READY;
      stall_cnt <= '0;
    end else begin
      state     <= next_state;
      stall_cnt <= next_stall_cnt;
    end
  end

  // Ready depends only on state so the sender never sees a valid->ready loop.
  always_comb begin
    next_state     = state;
    next_stall_cnt = stall_cnt;
    packet_ready   = 1'b0;
    transfer       = 1'b0;
    case (state)
      EJ_READY: begin
        packet_ready = 1'b1;
        transfer     = packet_valid;
        if (packet_valid && (EJECT_CYCLE > 1)) begin
          next_state     = EJ_STALL;
          next_stall_cnt = CNT_W'(EJECT_CYCLE - 1);
        end
      end
      EJ_STALL: begin
        if (stall_cnt <= CNT_W'(1)) begin
          next_state     = EJ_READY;
          next_stall_cnt = '0;
        end else begin
          next_stall_cnt = stall_cnt - CNT_W'(1);
        end
      end
      default: begin
        next_state     = EJ_READY;
        next_stall_cnt = '0;
      end
    endcase
  end

  // Capture stage: holds each accepted packet for exactly one cycle, so a
  // new capture and the stats update of the previous one share an edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_ts    <= '0;
      s1_now   <= '0;
      s1_src   <= '0;
      s1_dst   <= '0;
    end else if (transfer) begin
      s1_valid <= packet[VALID_BIT];
      s1_ts    <= packet[TS_MSB:TS_LSB];
      s1_now   <= clk_counter;
      s1_src   <= packet[SRC_MSB:SRC_LSB];
      s1_dst   <= packet[DST_MSB:DST_LSB];
    end else begin
      s1_valid <= 1'b0;
    end
  end

  packet_sink_stats #(
    .ROUTER_ID            (ROUTER_ID),
    .NUM_PACKETS_EXPECTED (NUM_PACKETS_EXPECTED)
  ) u_stats (
    .clk                   (clk),
    .rst_n                 (rst_n),
    .s1_valid              (s1_valid),
    .s1_ts                 (s1_ts),
    .s1_now                (s1_now),
    .s1_src                (s1_src),
    .s1_dst                (s1_dst),
    .total_packet_received (total_packet_received),
    .total_latency         (total_latency),
    .max_latency           (max_latency),
    .misrouted_cnt         (misrouted_cnt),
    .last_src              (last_src),
    .all_received          (all_received)
  );

endmodule

// File: tb/tb_packet_sink_local.sv
// Directed bench for packet_sink_local: one instance with single-cycle
// ejection for stats checks, one with EJECT_CYCLE=3 for throttle and reset.
module tb_packet_sink_local;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] clk_counter = '0;

  logic        a_valid = 1'b0;
  logic [48:0] a_packet = '0;
  logic        a_ready;
  logic [63:0] a_total, a_lat;
  logic [15:0] a_max, a_mis, a_src;
  logic        a_all;

  logic        b_valid = 1'b0;
  logic [48:0] b_packet = '0;
  logic        b_ready;
  logic [63:0] b_total, b_lat;
  logic [15:0] b_max, b_mis, b_src;
  logic        b_all;

  int checks = 0;
  int passed = 0;

  typedef struct {
    logic        vbit;
    logic [15:0] ts;
    logic [15:0] src;
    logic [15:0] dst;
    logic [15:0] now;
    logic [63:0] e_total;
    logic [63:0] e_lat;
    logic [15:0] e_max;
    logic [15:0] e_mis;
    logic [15:0] e_src;
  } vec_t;

  vec_t vecs[6];

  always #5 clk = ~clk;

  packet_sink_local #(
    .NUM_NODES(8), .ROUTER_ID(3), .PACKET_SIZE(49),
    .EJECT_CYCLE(1), .NUM_PACKETS_EXPECTED(20)
  ) dut_a (
    .clk(clk), .rst_n(rst_n), .clk_counter(clk_counter),
    .packet_valid(a_valid), .packet(a_packet), .packet_ready(a_ready),
    .total_packet_received(a_total), .total_latency(a_lat),
    .max_latency(a_max), .misrouted_cnt(a_mis), .last_src(a_src),
    .all_received(a_all)
  );

  packet_sink_local #(
    .NUM_NODES(8), .ROUTER_ID(3), .PACKET_SIZE(49),
    .EJECT_CYCLE(3), .NUM_PACKETS_EXPECTED(20)
  ) dut_b (
    .clk(clk), .rst_n(rst_n), .clk_counter(clk_counter),
    .packet_valid(b_valid), .packet(b_packet), .packet_ready(b_ready),
    .total_packet_received(b_total), .total_latency(b_lat),
    .max_latency(b_max), .misrouted_cnt(b_mis), .last_src(b_src),
    .all_received(b_all)
  );

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    checks++;
    if (actual === expected) passed++;
    else $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One packet into dut_a: transfer edge, then the stats edge.
  task automatic applyStimulus(input vec_t v);
    a_packet    = {v.vbit, v.ts, v.src, v.dst};
    clk_counter = v.now;
    a_valid     = 1'b1;
    checkOutput("a_ready_before_xfer", {63'd0, a_ready}, 64'd1);
    tick();
    a_valid = 1'b0;
    tick();
  endtask

  initial begin
    vecs[0] = '{1'b1, 16'd100,    16'd4, 16'd3, 16'd117,  64'd1, 64'd17, 16'd17, 16'd0, 16'd4};
    vecs[1] = '{1'b1, 16'hFFF0,   16'd2, 16'd3, 16'h0005, 64'd2, 64'd38, 16'd21, 16'd0, 16'd2};
    vecs[2] = '{1'b1, 16'd200,    16'd6, 16'd5, 16'd210,  64'd3, 64'd48, 16'd21, 16'd1, 16'd6};
    vecs[3] = '{1'b0, 16'd0,      16'd7, 16'd5, 16'd1000, 64'd3, 64'd48, 16'd21, 16'd1, 16'd6};
    vecs[4] = '{1'b1, 16'd10,     16'd1, 16'd3, 16'd60,   64'd4, 64'd98, 16'd50, 16'd1, 16'd1};
    vecs[5] = '{1'b1, 16'd300,    16'd0, 16'd0, 16'd300,  64'd5, 64'd98, 16'd50, 16'd2, 16'd0};

    // Reset state
    rst_n = 1'b0;
    tick();
    tick();
    checkOutput("rst_a_ready", {63'd0, a_ready}, 64'd1);
    checkOutput("rst_b_ready", {63'd0, b_ready}, 64'd1);
    checkOutput("rst_a_total", a_total, 64'd0);
    checkOutput("rst_a_lat", a_lat, 64'd0);
    checkOutput("rst_a_max", {48'd0, a_max}, 64'd0);
    checkOutput("rst_a_all", {63'd0, a_all}, 64'd0);
    rst_n = 1'b1;
    tick();

    // Table-driven stats vectors
    for (int i = 0; i < 6; i++) begin
      applyStimulus(vecs[i]);
      checkOutput($sformatf("v%0d_total", i), a_total, vecs[i].e_total);
      checkOutput($sformatf("v%0d_lat", i), a_lat, vecs[i].e_lat);
      checkOutput($sformatf("v%0d_max", i), {48'd0, a_max}, {48'd0, vecs[i].e_max});
      checkOutput($sformatf("v%0d_mis", i), {48'd0, a_mis}, {48'd0, vecs[i].e_mis});
      checkOutput($sformatf("v%0d_src", i), {48'd0, a_src}, {48'd0, vecs[i].e_src});
      checkOutput($sformatf("v%0d_all", i), {63'd0, a_all}, 64'd0);
    end

    // 20 back-to-back packets, latency 2 each
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    for (int i = 0; i < 20; i++) begin
      clk_counter = 16'(1000 + i);
      a_packet    = {1'b1, 16'(998 + i), 16'd1, 16'd3};
      a_valid     = 1'b1;
      tick();
      checkOutput($sformatf("b2b%0d_total", i), a_total, 64'(i));
      checkOutput($sformatf("b2b%0d_all", i), {63'd0, a_all}, 64'd0);
    end
    a_valid = 1'b0;
    tick();
    checkOutput("b2b_final_total", a_total, 64'd20);
    checkOutput("b2b_final_lat", a_lat, 64'd40);
    checkOutput("b2b_all_rise", {63'd0, a_all}, 64'd1);
    tick();
    tick();
    checkOutput("b2b_all_sticky", {63'd0, a_all}, 64'd1);

    // EJECT_CYCLE=3, valid held for 10 edges: transfers at 0,3,6,9
    b_packet    = {1'b1, 16'd50, 16'd2, 16'd3};
    clk_counter = 16'd60;
    b_valid     = 1'b1;
    for (int k = 0; k < 10; k++) begin
      checkOutput($sformatf("stall_ready_e%0d", k), {63'd0, b_ready},
                  (k % 3 == 0) ? 64'd1 : 64'd0);
      tick();
    end
    b_valid = 1'b0;
    checkOutput("stall_ready_after9", {63'd0, b_ready}, 64'd0);
    tick();
    tick();
    tick();
    checkOutput("stall_total", b_total, 64'd4);
    checkOutput("stall_lat", b_lat, 64'd40);
    checkOutput("stall_ready_idle", {63'd0, b_ready}, 64'd1);

    // Reset mid-stall with S1 loaded
    b_packet = {1'b1, 16'd10, 16'd5, 16'd3};
    b_valid  = 1'b1;
    tick();
    b_valid = 1'b0;
    checkOutput("mid_ready_low", {63'd0, b_ready}, 64'd0);
    rst_n = 1'b0;
    #1;
    checkOutput("mid_rst_ready", {63'd0, b_ready}, 64'd1);
    checkOutput("mid_rst_total", b_total, 64'd0);
    checkOutput("mid_rst_lat", b_lat, 64'd0);
    checkOutput("mid_rst_src", {48'd0, b_src}, 64'd0);
    checkOutput("mid_rst_a_all", {63'd0, a_all}, 64'd0);
    tick();
    rst_n = 1'b1;
    tick();
    tick();
    tick();
    checkOutput("post_rst_total", b_total, 64'd0);
    checkOutput("post_rst_ready", {63'd0, b_ready}, 64'd1);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
